// File: rtl/inc_seq_pkg.sv
// Shared constants for the instruction-cycle sequencer: register select codes,
// opcodes and the state enumeration.
package inc_seq_pkg;

    localparam logic [2:0] CODE_AC   = 3'b000;
    localparam logic [2:0] CODE_AR   = 3'b001;
    localparam logic [2:0] CODE_DR   = 3'b010;
    localparam logic [2:0] CODE_IR   = 3'b011;
    localparam logic [2:0] CODE_PC   = 3'b100;
    localparam logic [2:0] CODE_R    = 3'b101;
    localparam logic [2:0] CODE_TR   = 3'b110;
    localparam logic [2:0] CODE_NONE = 3'b111;
    // On the bus select the all-ones code routes memory read data.
    localparam logic [2:0] CODE_MEM  = 3'b111;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_INCAC = 4'h1;
    localparam logic [3:0] OP_SKZ   = 4'h2;
    localparam logic [3:0] OP_ISZ   = 4'h5;
    localparam logic [3:0] OP_DELAY = 4'h6;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        FETCH_A = 4'd1,
        FETCH_M = 4'd2,
        FETCH_I = 4'd3,
        DECODE  = 4'd4,
        EX_INC  = 4'd5,
        EX_SKZ  = 4'd6,
        ISZ_A   = 4'd7,
        ISZ_R   = 4'd8,
        ISZ_I   = 4'd9,
        ISZ_W   = 4'd10,
        EX_DLY  = 4'd11,
        TRAP    = 4'd12
    } state_t;

endpackage

// File: rtl/inc_seq_dly_cnt.sv
// 4-bit loadable down-counter for the DELAY instruction; last flags count==1.
module inc_seq_dly_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       last
);

    logic [3:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    assign last = (count == 4'd1);

endmodule

// File: rtl/inc_sequencer.sv
// Fetch/decode/execute control sequencer driving increment, load and bus selects.
// Optional build macro INC_SEQ_ILLEGAL_TRAP_EN: undefined opcodes lock into TRAP.
module inc_sequencer
    import inc_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       halt_req,
    input  logic [3:0] opcode,
    input  logic [3:0] operand,
    input  logic       z_flag,
    input  logic       dr_zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic [2:0] inc_sel,
    output logic [2:0] ld_sel,
    output logic [2:0] bus_sel,
    output logic       busy,
    output logic       illegal
);

    state_t state, state_nxt, boundary;
    logic   dly_load, dly_dec, dly_last;

    inc_seq_dly_cnt u_dly_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (dly_load),
        .load_val (operand),
        .dec      (dly_dec),
        .last     (dly_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign busy = (state != IDLE);

    always_comb begin
        state_nxt = state;
        boundary  = halt_req ? IDLE : FETCH_A;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        inc_sel   = CODE_NONE;
        ld_sel    = CODE_NONE;
        bus_sel   = CODE_NONE;
        illegal   = 1'b0;
        dly_load  = 1'b0;
        dly_dec   = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = FETCH_A;
            end
            FETCH_A: begin
                bus_sel   = CODE_PC;
                ld_sel    = CODE_AR;
                state_nxt = FETCH_M;
            end
            FETCH_M: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    bus_sel   = CODE_MEM;
                    ld_sel    = CODE_DR;
                    inc_sel   = CODE_PC;
                    state_nxt = FETCH_I;
                end
            end
            FETCH_I: begin
                bus_sel   = CODE_DR;
                ld_sel    = CODE_IR;
                state_nxt = DECODE;
            end
            DECODE: begin
                case (opcode)
                    OP_NOP:   state_nxt = boundary;
                    OP_INCAC: state_nxt = EX_INC;
                    OP_SKZ:   state_nxt = EX_SKZ;
                    OP_ISZ:   state_nxt = ISZ_A;
                    OP_DELAY: begin
                        if (operand == 4'd0) begin
                            state_nxt = boundary;
                        end else begin
                            dly_load  = 1'b1;
                            state_nxt = EX_DLY;
                        end
                    end
                    OP_HALT:  state_nxt = IDLE;
                    default: begin
                        illegal = 1'b1;
`ifdef INC_SEQ_ILLEGAL_TRAP_EN
                        state_nxt = TRAP;
`else
                        state_nxt = boundary;
`endif
                    end
                endcase
            end
            EX_INC: begin
                inc_sel   = CODE_AC;
                state_nxt = boundary;
            end
            EX_SKZ: begin
                inc_sel   = z_flag ? CODE_PC : CODE_NONE;
                state_nxt = boundary;
            end
            ISZ_A: begin
                bus_sel   = CODE_IR;
                ld_sel    = CODE_AR;
                state_nxt = ISZ_R;
            end
            ISZ_R: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    bus_sel   = CODE_MEM;
                    ld_sel    = CODE_DR;
                    state_nxt = ISZ_I;
                end
            end
            ISZ_I: begin
                inc_sel   = CODE_DR;
                state_nxt = ISZ_W;
            end
            ISZ_W: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                bus_sel = CODE_DR;
                if (mem_ack) begin
                    inc_sel   = dr_zero ? CODE_PC : CODE_NONE;
                    state_nxt = boundary;
                end
            end
            EX_DLY: begin
                inc_sel = CODE_TR;
                dly_dec = 1'b1;
                if (dly_last) state_nxt = boundary;
            end
            TRAP: begin
                // Only reachable with the trap build; reset is the sole exit.
                illegal   = 1'b1;
                state_nxt = TRAP;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_inc_sequencer.sv
// Directed bench for inc_sequencer: per-cycle expected output vectors are queued
// from the instruction timing and compared cycle by cycle.
module tb_inc_sequencer;
    import inc_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, halt_req, z_flag, dr_zero, mem_ack;
    logic [3:0] opcode, operand;
    logic       mem_req, mem_we, busy, illegal;
    logic [2:0] inc_sel, ld_sel, bus_sel;

    int n_pass = 0;
    int n_total = 0;

    logic [12:0] exp_q[$];
    int          ack_q[$];

    localparam logic [2:0] N = CODE_NONE;

    inc_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .halt_req (halt_req),
        .opcode   (opcode),
        .operand  (operand),
        .z_flag   (z_flag),
        .dr_zero  (dr_zero),
        .mem_ack  (mem_ack),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .inc_sel  (inc_sel),
        .ld_sel   (ld_sel),
        .bus_sel  (bus_sel),
        .busy     (busy),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] vec(input logic req, input logic we,
                                        input logic [2:0] inc, input logic [2:0] ld,
                                        input logic [2:0] bus, input logic bsy,
                                        input logic ill);
        return {req, we, inc, ld, bus, bsy, ill};
    endfunction

    function automatic logic [12:0] observed();
        return {mem_req, mem_we, inc_sel, ld_sel, bus_sel, busy, illegal};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // ack: 0/1 drive that value, -1 = random (only where mem_req is low)
    task automatic exp_cycle(input logic [12:0] v, input int ack);
        exp_q.push_back(v);
        ack_q.push_back(ack);
    endtask

    task automatic exp_fetch(input int waits);
        exp_cycle(vec(0, 0, N, CODE_AR, CODE_PC, 1, 0), -1);
        for (int i = 0; i < waits; i++) exp_cycle(vec(1, 0, N, N, N, 1, 0), 0);
        exp_cycle(vec(1, 0, CODE_PC, CODE_DR, CODE_MEM, 1, 0), 1);
        exp_cycle(vec(0, 0, N, CODE_IR, CODE_DR, 1, 0), -1);
    endtask

    task automatic run_trace(input string tag);
        int i = 0;
        int a;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            a = ack_q.pop_front();
            mem_ack = (a < 0) ? 1'($urandom_range(0, 1)) : a[0];
            #1;
            check($sformatf("%s_c%0d", tag, i), 32'(observed()), 32'(exp_q.pop_front()));
            i++;
        end
    endtask

    task automatic instr(input logic [3:0] op, input logic [3:0] opd,
                         input logic z, input logic drz, input logic halt);
        @(posedge clk);
        #1;
        start    = 1'b0;
        opcode   = op;
        operand  = opd;
        z_flag   = z;
        dr_zero  = drz;
        halt_req = halt;
    endtask

    task automatic do_start(input string tag);
        @(negedge clk);
        start   = 1'b1;
        mem_ack = 1'($urandom_range(0, 1));
        #1;
        check(tag, 32'(observed()), 32'(vec(0, 0, N, N, N, 0, 0)));
    endtask

    initial begin
        rst_n = 1'b0; start = 0; halt_req = 0; z_flag = 0; dr_zero = 0; mem_ack = 0;
        opcode = OP_NOP; operand = 4'd0;
        #1;
        check("reset_outputs", 32'(observed()), 32'(vec(0, 0, N, N, N, 0, 0)));
        check("reset_state", 32'(dut.state), 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;

        do_start("idle_start");

        // NOP, zero-wait: 4 cycles, one PC increment
        instr(OP_NOP, 4'd0, 0, 0, 0);
        exp_fetch(0);
        exp_cycle(vec(0, 0, N, N, N, 1, 0), -1);
        run_trace("nop");

        // INCAC with two wait cycles: 7 cycles
        instr(OP_INCAC, 4'd0, 0, 0, 0);
        exp_fetch(2);
        exp_cycle(vec(0, 0, N, N, N, 1, 0), -1);
        exp_cycle(vec(0, 0, CODE_AC, N, N, 1, 0), -1);
        run_trace("incac_w2");

        for (int z = 1; z >= 0; z--) begin
            instr(OP_SKZ, 4'd0, 1'(z), 0, 0);
            exp_fetch(0);
            exp_cycle(vec(0, 0, N, N, N, 1, 0), -1);
            exp_cycle(vec(0, 0, (z == 1) ? CODE_PC : N, N, N, 1, 0), -1);
            run_trace($sformatf("skz_z%0d", z));
        end

        // ISZ: read zero-wait, write with one wait cycle
        for (int d = 1; d >= 0; d--) begin
            instr(OP_ISZ, 4'hA, 0, 1'(d), 0);
            exp_fetch(0);
            exp_cycle(vec(0, 0, N, N, N, 1, 0), -1);
            exp_cycle(vec(0, 0, N, CODE_AR, CODE_IR, 1, 0), -1);
            exp_cycle(vec(1, 0, N, CODE_DR, CODE_MEM, 1, 0), 1);
            exp_cycle(vec(0, 0, CODE_DR, N, N, 1, 0), -1);
            exp_cycle(vec(1, 1, N, N, CODE_DR, 1, 0), 0);
            exp_cycle(vec(1, 1, (d == 1) ? CODE_PC : N, N, CODE_DR, 1, 0), 1);
            run_trace($sformatf("isz_drz%0d", d));
        end

        instr(OP_DELAY, 4'd3, 0, 0, 0);
        exp_fetch(0);
        exp_cycle(vec(0, 0, N, N, N, 1, 0), -1);
        for (int i = 0; i < 3; i++) exp_cycle(vec(0, 0, CODE_TR, N, N, 1, 0), -1);
        run_trace("delay3");

        instr(OP_DELAY, 4'd0, 0, 0, 0);
        exp_fetch(0);
        exp_cycle(vec(0, 0, N, N, N, 1, 0), -1);
        run_trace("delay0");

        // NOP with halt_req at the boundary returns to IDLE
        instr(OP_NOP, 4'd0, 0, 0, 1);
        exp_fetch(0);
        exp_cycle(vec(0, 0, N, N, N, 1, 0), -1);
        run_trace("nop_halt");
        do_start("idle_after_halt");

        instr(OP_HALT, 4'd0, 0, 0, 0);
        exp_fetch(0);
        exp_cycle(vec(0, 0, N, N, N, 1, 0), -1);
        run_trace("halt");
        do_start("idle_after_haltop");

        instr(4'h7, 4'd0, 0, 0, 0);
        exp_fetch(0);
        exp_cycle(vec(0, 0, N, N, N, 1, 1), -1);
`ifdef INC_SEQ_ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) exp_cycle(vec(0, 0, N, N, N, 1, 1), -1);
        run_trace("illegal_trap");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("trap_reset_state", 32'(dut.state), 32'(IDLE));
        rst_n = 1'b1;
        do_start("idle_after_trap");
`else
        run_trace("illegal");
`endif

        // Reset pulse while FETCH_M waits for ack
        instr(OP_NOP, 4'd0, 0, 0, 0);
        exp_cycle(vec(0, 0, N, CODE_AR, CODE_PC, 1, 0), -1);
        exp_cycle(vec(1, 0, N, N, N, 1, 0), 0);
        exp_cycle(vec(1, 0, N, N, N, 1, 0), 0);
        run_trace("fetch_wait");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'(observed()), 32'(vec(0, 0, N, N, N, 0, 0)));
        check("async_reset_state", 32'(dut.state), 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        mem_ack = 1'b0;
        #1;
        check("post_reset_idle", 32'(observed()), 32'(vec(0, 0, N, N, N, 0, 0)));
        @(posedge clk);
        #1;
        check("post_reset_stays_idle", 32'(dut.state), 32'(IDLE));
        check("post_reset_outputs", 32'(observed()), 32'(vec(0, 0, N, N, N, 0, 0)));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
